led_matrix_scan: RTL and testbench

Parametrised multiplexed LED-matrix driver for the ice40up5k board, running from the 48 MHz internal oscillator clock. It scans an N_ROWS × N_COLS matrix row by row. Each LED gets 2^PWM_BITS-level PWM brightness and one of four modes: off, on, blink, or inverted blink. A synchronous write port updates per-LED settings. Outputs go straight to the anode row pins and, through the tri-state IO cells in top, to the cathode column pins.

---
 rtl/led_matrix_scan.sv | 185 ++++++++++++++++++
 tb/tb_led_matrix_scan.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row-multiplexed LED-matrix driver.
// Each LED has PWM brightness and an off/on/blink/inverted-blink mode.
// Rows are scanned one at a time. Every row slot starts with one blank
// tick, which keeps a row and the next row's column pattern from ever
// overlapping on the pins.
module led_matrix_scan #(
  parameter int N_ROWS       = 4,
  parameter int N_COLS       = 4,
  parameter int PWM_BITS     = 4,
  parameter int TICK_DIV     = 64,
  parameter int BLINK_FRAMES = 5500
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             wr_en,
  input  logic [$clog2(N_ROWS*N_COLS)-1:0] wr_addr,
  input  logic [PWM_BITS+1:0]              wr_data,
  output logic [N_ROWS-1:0]                aled,
  output logic [N_COLS-1:0]                kled_tri,
  output logic                             frame_start
);

  localparam int N_LEDS = N_ROWS * N_COLS;
  localparam int ADDR_W = $clog2(N_LEDS);
  localparam int ENT_W  = PWM_BITS + 2;
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [ROW_W-1:0]    ROW_MAX = ROW_W'(N_ROWS - 1);
  localparam logic [FRM_W-1:0]    FRM_MAX = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_PWM   = 1'b1;

  logic [ENT_W-1:0]    ram_q [N_LEDS];
  logic                addrOk;

  logic                started_q;
  logic [PRE_W-1:0]    prescale_q, prescale_d;
  logic [0:0]          state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;
  logic                tick;
  logic                enterFrame;

  logic [FRM_W-1:0]    frameCnt_q, frameCnt_d;
  logic                blinkPhase_q, blinkPhase_d;

  logic [N_ROWS-1:0]   aled_q, aled_d;
  logic [N_COLS-1:0]   kled_q, kled_d;
  logic                frameStart_q;

  assign aled        = aled_q;
  assign kled_tri    = kled_q;
  assign frame_start = frameStart_q;

  assign addrOk = (int'(wr_addr) < N_LEDS);

  // Settings RAM: cleared by reset, out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < N_LEDS; i++) begin
        ram_q[i] <= '0;
      end
    end else if (wr_en && addrOk) begin
      ram_q[wr_addr] <= wr_data;
    end
  end

  // Scan sequencing: prescaler, blank/PWM state, PWM counter and row index
  always_comb begin
    tick       = (prescale_q == PRE_MAX);
    prescale_d = tick ? '0 : prescale_q + 1'b1;
    state_d    = state_q;
    row_d      = row_q;
    pwmCnt_d   = pwmCnt_q;
    enterFrame = 1'b0;
    if (!started_q) begin
      // First cycle out of reset opens the blank tick of row 0 with a full prescaler period
      prescale_d = '0;
      enterFrame = 1'b1;
    end else if (tick) begin
      if (state_q == ST_BLANK) begin
        state_d  = ST_PWM;
        pwmCnt_d = '0;
      end else if (pwmCnt_q == PWM_MAX) begin
        state_d    = ST_BLANK;
        pwmCnt_d   = '0;
        row_d      = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
        enterFrame = (row_q == ROW_MAX);
      end else begin
        pwmCnt_d = pwmCnt_q + 1'b1;
      end
    end
  end

  // Scan state registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      started_q  <= 1'b0;
      prescale_q <= '0;
      state_q    <= ST_BLANK;
      row_q      <= '0;
      pwmCnt_q   <= '0;
    end else begin
      started_q  <= 1'b1;
      prescale_q <= prescale_d;
      state_q    <= state_d;
      row_q      <= row_d;
      pwmCnt_q   <= pwmCnt_d;
    end
  end

  // Blink phase flips after every BLINK_FRAMES frame_start pulses
  always_comb begin
    frameCnt_d   = frameCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (frameStart_q) begin
      if (frameCnt_q == FRM_MAX) begin
        frameCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        frameCnt_d = frameCnt_q + 1'b1;
      end
    end
  end

  // Blink counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frameCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else begin
      frameCnt_q   <= frameCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  // Pin pattern for the upcoming cycle, built from the next scan position.
  // The incoming blink phase is used so a whole frame sees a single phase.
  always_comb begin
    logic [ADDR_W-1:0]   ledIdx;
    logic [ENT_W-1:0]    entry;
    logic [PWM_BITS-1:0] bright;
    logic                modeEn;
    aled_d = '0;
    kled_d = '1;
    ledIdx = '0;
    entry  = '0;
    bright = '0;
    modeEn = 1'b0;
    if (state_d == ST_PWM) begin
      aled_d = N_ROWS'(1'b1) << row_d;
      for (int c = 0; c < N_COLS; c++) begin
        ledIdx = ADDR_W'(int'(row_d) * N_COLS + c);
        entry  = ram_q[ledIdx];
        bright = entry[PWM_BITS-1:0];
        case (entry[ENT_W-1:ENT_W-2])
          2'b00:   modeEn = 1'b0;
          2'b01:   modeEn = 1'b1;
          2'b10:   modeEn = blinkPhase_d;
          default: modeEn = ~blinkPhase_d;
        endcase
        kled_d[c] = ~(modeEn && (pwmCnt_d < bright));
      end
    end
  end

  // Output registers; reset forces a dark, deselected matrix immediately
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aled_q       <= '0;
      kled_q       <= '1;
      frameStart_q <= 1'b0;
    end else begin
      aled_q       <= aled_d;
      kled_q       <= kled_d;
      frameStart_q <= enterFrame;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: directed checks of led_matrix_scan.
// Instance A is 4x4 with one clk per tick and a 2-frame blink period.
// Instance B is 3x4 with three clks per tick, which leaves addresses 12..15
// out of range for the write port.
module tb_led_matrix_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       wrEnA;
  logic [3:0] wrAddrA;
  logic [5:0] wrDataA;
  logic [3:0] aledA;
  logic [3:0] kledA;
  logic       fsA;
  logic       wrEnB;
  logic [3:0] wrAddrB;
  logic [5:0] wrDataB;
  logic [2:0] aledB;
  logic [3:0] kledB;
  logic       fsB;

  led_matrix_scan #(.N_ROWS(4), .N_COLS(4), .PWM_BITS(4), .TICK_DIV(1), .BLINK_FRAMES(2)) dutA (
    .clk(clk), .resetn(resetn), .wr_en(wrEnA), .wr_addr(wrAddrA), .wr_data(wrDataA),
    .aled(aledA), .kled_tri(kledA), .frame_start(fsA)
  );

  led_matrix_scan #(.N_ROWS(3), .N_COLS(4), .PWM_BITS(4), .TICK_DIV(3), .BLINK_FRAMES(5500)) dutB (
    .clk(clk), .resetn(resetn), .wr_en(wrEnB), .wr_addr(wrAddrB), .wr_data(wrDataB),
    .aled(aledB), .kled_tri(kledB), .frame_start(fsB)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [5:0]  data;
    int          row;
    int          col;
    logic [15:0] expMask;
  } vec_t;

  vec_t        vecs [8];
  int          vecCount = 0;
  int          missCount = 0;
  logic [5:0]  modelA [16];
  logic [5:0]  modelB [12];
  logic [15:0] capMask [4][4];
  int          scanErr;
  int          frmA = 0;

  // Count frame_start pulses of instance A since the last reset
  always @(posedge clk) begin
    if (!resetn) frmA <= 0;
    else if (fsA) frmA <= frmA + 1;
  end

  // Hard stop in case something stalls beyond every local bound
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s: bound expired, required event not seen", name);
  endtask

  function automatic void sampleDut(input int sel, output logic [3:0] al, output logic [3:0] kl, output logic fs);
    if (sel == 0) begin
      al = aledA; kl = kledA; fs = fsA;
    end else begin
      al = {1'b0, aledB}; kl = kledB; fs = fsB;
    end
  endfunction

  function automatic logic [15:0] modelMask(input logic [5:0] e, input logic phase);
    logic en;
    case (e[5:4])
      2'b00:   en = 1'b0;
      2'b01:   en = 1'b1;
      2'b10:   en = phase;
      default: en = ~phase;
    endcase
    return en ? ((16'd1 << e[3:0]) - 16'd1) : 16'd0;
  endfunction

  // One write, driven at a negedge and held across one posedge
  task automatic applyStimulus(input int sel, input logic [3:0] addr, input logic [5:0] data);
    @(negedge clk);
    if (sel == 0) begin
      wrEnA = 1'b1; wrAddrA = addr; wrDataA = data;
    end else begin
      wrEnB = 1'b1; wrAddrB = addr; wrDataB = data;
    end
    @(negedge clk);
    wrEnA = 1'b0;
    wrEnB = 1'b0;
    if (resetn) begin
      if (sel == 0) modelA[addr] = data;
      else if (addr < 4'd12) modelB[addr] = data;
    end
  endtask

  task automatic waitFrameStart(input int sel, output logic ok);
    logic [3:0] al, kl;
    logic fs;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      sampleDut(sel, al, kl, fs);
      if (fs === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failNow("frame_start wait");
  endtask

  // Records one frame starting at the current (frame_start) negedge
  task automatic captureFrame(input int sel, input int nRows, input int td);
    int rowLen;
    int r, j, k;
    int cnt [4][4][16];
    logic [3:0] al, kl;
    logic fs;
    rowLen  = 17 * td;
    scanErr = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int p = 0; p < 16; p++) cnt[a][b][p] = 0;
    for (int i = 0; i < nRows * rowLen; i++) begin
      if (i > 0) @(negedge clk);
      sampleDut(sel, al, kl, fs);
      r = i / rowLen;
      j = i % rowLen;
      if (fs !== (i == 0)) scanErr++;
      if (j < td) begin
        if (al !== 4'b0000 || kl !== 4'hF) scanErr++;
      end else begin
        k = (j - td) / td;
        if (al !== (4'b0001 << r)) scanErr++;
        for (int c = 0; c < 4; c++) begin
          if (kl[c] === 1'b0) cnt[r][c][k]++;
          else if (kl[c] !== 1'b1) scanErr++;
        end
      end
    end
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        capMask[a][b] = '0;
        for (int p = 0; p < 16; p++) begin
          if (cnt[a][b][p] == td) capMask[a][b][p] = 1'b1;
          else if (cnt[a][b][p] != 0) scanErr++;
        end
      end
  endtask

  task automatic compareFrame(input int sel, input int nRows, input logic phase, input string name);
    int diffs;
    logic [5:0] e;
    diffs = 0;
    for (int r = 0; r < nRows; r++)
      for (int c = 0; c < 4; c++) begin
        e = (sel == 0) ? modelA[r*4+c] : modelB[r*4+c];
        if (capMask[r][c] !== modelMask(e, phase)) begin
          diffs++;
          $display("[TB] led r%0d c%0d lit pattern 0x%0h, model 0x%0h", r, c, capMask[r][c], modelMask(e, phase));
        end
      end
    checkOutput({name, " scan"}, scanErr, 0);
    checkOutput({name, " leds"}, diffs, 0);
  endtask

  task automatic measurePeriod(input int sel, input int expected, input string name);
    logic ok;
    logic [3:0] al, kl;
    logic fs;
    int n;
    waitFrameStart(sel, ok);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      sampleDut(sel, al, kl, fs);
      if (fs === 1'b1) break;
    end
    checkOutput(name, n, expected);
  endtask

  task automatic clearModels();
    for (int i = 0; i < 16; i++) modelA[i] = '0;
    for (int i = 0; i < 12; i++) modelB[i] = '0;
  endtask

  initial begin
    logic ok;
    int f;
    vecs[0] = '{4'd5,  {2'b01, 4'd8},  1, 1, 16'h00FF};
    vecs[1] = '{4'd6,  {2'b01, 4'd0},  1, 2, 16'h0000};
    vecs[2] = '{4'd7,  {2'b01, 4'd15}, 1, 3, 16'h7FFF};
    vecs[3] = '{4'd0,  {2'b01, 4'd1},  0, 0, 16'h0001};
    vecs[4] = '{4'd15, {2'b00, 4'd15}, 3, 3, 16'h0000};
    vecs[5] = '{4'd10, {2'b01, 4'd3},  2, 2, 16'h0007};
    vecs[6] = '{4'd12, {2'b01, 4'd14}, 3, 0, 16'h3FFF};
    vecs[7] = '{4'd5,  {2'b00, 4'd8},  1, 1, 16'h0000};

    resetn = 1'b0;
    wrEnA = 1'b0; wrAddrA = '0; wrDataA = '0;
    wrEnB = 1'b0; wrAddrB = '0; wrDataB = '0;
    clearModels();
    repeat (3) @(negedge clk);

    // Writes during reset must be dropped
    applyStimulus(0, 4'd3, {2'b01, 4'd15});
    checkOutput("reset aledA", aledA, 4'h0);
    checkOutput("reset kledA", kledA, 4'hF);
    checkOutput("reset fsA", fsA, 1'b0);
    checkOutput("reset aledB", aledB, 3'h0);
    checkOutput("reset kledB", kledB, 4'hF);

    resetn = 1'b1;
    checkOutput("release fsA", fsA, 1'b0);
    @(negedge clk);
    checkOutput("first fsA", fsA, 1'b1);
    checkOutput("first fsB", fsB, 1'b1);
    checkOutput("first blank aledA", aledA, 4'h0);
    captureFrame(0, 4, 1);
    compareFrame(0, 4, 1'b0, "frame1 all dark");

    measurePeriod(0, 68, "periodA");
    measurePeriod(1, 153, "periodB");

    // Table of single-LED writes on instance A
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, vecs[i].addr, vecs[i].data);
      waitFrameStart(0, ok);
      captureFrame(0, 4, 1);
      checkOutput($sformatf("vec%0d mask", i), capMask[vecs[i].row][vecs[i].col], vecs[i].expMask);
      compareFrame(0, 4, 1'b0, $sformatf("vec%0d", i));
    end

    // Instance B: tick scaling, brightness extremes and out-of-range writes
    applyStimulus(1, 4'd5, {2'b01, 4'd8});
    applyStimulus(1, 4'd6, {2'b01, 4'd0});
    applyStimulus(1, 4'd7, {2'b01, 4'd15});
    applyStimulus(1, 4'd12, {2'b01, 4'd15});
    applyStimulus(1, 4'd15, {2'b01, 4'd15});
    waitFrameStart(1, ok);
    captureFrame(1, 3, 3);
    checkOutput("B r1c1 b8", capMask[1][1], 16'h00FF);
    checkOutput("B r1c2 b0", capMask[1][2], 16'h0000);
    checkOutput("B r1c3 b15", capMask[1][3], 16'h7FFF);
    checkOutput("B r0c0 untouched", capMask[0][0], 16'h0000);
    compareFrame(1, 3, 1'b0, "B frame");

    // Reset in the middle of row 2 PWM
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (aledA === 4'b0100) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failNow("row2 wait");
    resetn = 1'b0;
    clearModels();
    @(negedge clk);
    checkOutput("midreset aledA", aledA, 4'h0);
    checkOutput("midreset kledA", kledA, 4'hF);
    checkOutput("midreset fsA", fsA, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("restart fsA", fsA, 1'b1);
    captureFrame(0, 4, 1);
    compareFrame(0, 4, 1'b0, "after midreset");

    // Blink modes: capture frames 2..5, judge the odd ones
    resetn = 1'b0;
    clearModels();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    applyStimulus(0, 4'd0, {2'b10, 4'd15});
    applyStimulus(0, 4'd1, {2'b11, 4'd15});
    f = 0;
    for (int n = 0; n < 6 && f < 5; n++) begin
      waitFrameStart(0, ok);
      f = frmA + 1;
      captureFrame(0, 4, 1);
      if (f == 3 || f == 5) begin
        checkOutput($sformatf("blink f%0d mode10", f), capMask[0][0], (f == 3) ? 16'h7FFF : 16'h0000);
        checkOutput($sformatf("blink f%0d mode11", f), capMask[0][1], (f == 3) ? 16'h0000 : 16'h7FFF);
        compareFrame(0, 4, logic'((f / 2) % 2), $sformatf("blink f%0d", f));
      end
    end
    checkOutput("blink frames reached", f, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
